// File: rtl/eq_sequencer.sv
// Five-band EQ sequencer: steps a shared stereo MAC through NUM_TAPS taps per band after each sample pair.
// Optional `EQ_SEQ_SKIP_EN skips bands whose band_en bit is clear.
module eq_sequencer #(
    parameter int NUM_TAPS = 31,
    parameter int TAP_W    = 5,
    parameter int MAC_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld,
    input  logic             q_full,
    input  logic [4:0]       band_en,
    input  logic             ovr_clr,
    output logic             wrt_smpl,
    output logic [2:0]       band,
    output logic [TAP_W-1:0] tap_addr,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             band_done,
    output logic             seq_done,
    output logic             busy,
    output logic             ovr
);

    typedef enum logic [2:0] {IDLE, WRT, CLR, MAC, PIPE, BDONE} state_t;

    localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(NUM_TAPS - 1);
    localparam logic [2:0]       PIPE_LAST = 3'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);
    localparam logic [2:0]       NO_BAND   = 3'd5;

    state_t             state_q, state_d;
    logic [2:0]         band_q, band_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [2:0]         pipe_q, pipe_d;
    logic               ovr_q, ovr_d;
    logic [4:0]         en;
    logic [2:0]         nb;

`ifdef EQ_SEQ_SKIP_EN
    assign en = band_en;
`else
    logic unused_band_en;
    assign unused_band_en = ^band_en;
    assign en = 5'h1F;
`endif

    // Lowest enabled band at or above 'from'; NO_BAND when none remain.
    function automatic logic [2:0] first_en(input logic [2:0] from, input logic [4:0] mask);
        first_en = NO_BAND;
        for (int i = 4; i >= 0; i--) begin
            if (i >= int'(from) && mask[i]) first_en = 3'(i);
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        band_d    = band_q;
        tap_d     = tap_q;
        pipe_d    = pipe_q;
        nb        = NO_BAND;
        wrt_smpl  = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        band_done = 1'b0;
        seq_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (vld) state_d = WRT;
            end
            WRT: begin
                wrt_smpl = 1'b1;
                if (q_full) begin
                    nb = first_en(3'd0, en);
                    if (nb == NO_BAND) begin
                        seq_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        band_d  = nb;
                        tap_d   = '0;
                        state_d = CLR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CLR: begin
                mac_clr = 1'b1;
                state_d = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap_q == LAST_TAP) begin
                    if (MAC_LAT == 0) begin
                        state_d = BDONE;
                    end else begin
                        pipe_d  = '0;
                        state_d = PIPE;
                    end
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            PIPE: begin
                if (pipe_q == PIPE_LAST) state_d = BDONE;
                else                     pipe_d  = pipe_q + 3'd1;
            end
            BDONE: begin
                band_done = 1'b1;
                nb = first_en(band_q + 3'd1, en);
                if (nb == NO_BAND) begin
                    seq_done = 1'b1;
                    band_d   = '0;
                    state_d  = IDLE;
                end else begin
                    band_d  = nb;
                    tap_d   = '0;
                    state_d = CLR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign band     = band_q;
    assign tap_addr = tap_q;
    assign ovr      = ovr_q;

    // A new sample while busy is dropped but flagged; setting beats clearing.
    assign ovr_d = (vld && busy) || (ovr_q && !ovr_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            band_q  <= '0;
            tap_q   <= '0;
            pipe_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
            tap_q   <= tap_d;
            pipe_q  <= pipe_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_eq_sequencer.sv
// Directed bench for eq_sequencer: default instance plus a NUM_TAPS=4, MAC_LAT=0 instance.
module tb_eq_sequencer;

    localparam int MAXC = 400;
    typedef bit log_t [MAXC];
    typedef int ilog_t [MAXC];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld = 1'b0;
    logic       q_full = 1'b1;
    logic [4:0] band_en = 5'h1F;
    logic       ovr_clr = 1'b0;

    logic       wrt_smpl, mac_clr, mac_en, band_done, seq_done, busy, ovr;
    logic [2:0] band;
    logic [4:0] tap_addr;

    logic       s_wrt, s_clr, s_en, s_bd, s_sd, s_busy, s_ovr;
    logic [2:0] s_band;
    logic [1:0] s_tap;

    int total = 0;
    int bad = 0;

    log_t  vld_at, clr_at, rst_at;
    log_t  wrt_l, clr_l, en_l, bd_l, sd_l, busy_l, ovr_l;
    ilog_t band_l, tap_l;
    log_t  s_wrt_l, s_en_l, s_bd_l, s_sd_l, s_busy_l;
    ilog_t s_tap_l;

    eq_sequencer dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .q_full(q_full), .band_en(band_en),
        .ovr_clr(ovr_clr), .wrt_smpl(wrt_smpl), .band(band), .tap_addr(tap_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .band_done(band_done), .seq_done(seq_done),
        .busy(busy), .ovr(ovr)
    );

    eq_sequencer #(.NUM_TAPS(4), .TAP_W(2), .MAC_LAT(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .vld(vld), .q_full(q_full), .band_en(band_en),
        .ovr_clr(ovr_clr), .wrt_smpl(s_wrt), .band(s_band), .tap_addr(s_tap),
        .mac_clr(s_clr), .mac_en(s_en), .band_done(s_bd), .seq_done(s_sd),
        .busy(s_busy), .ovr(s_ovr)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ones(input log_t a, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i < hi; i++) if (a[i]) n++;
        return n;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            vld_at[i] = 1'b0;
            clr_at[i] = 1'b0;
            rst_at[i] = 1'b0;
        end
    endtask

    // Cycle c: inputs applied at the falling edge, outputs sampled just after.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst_n   = !rst_at[c];
            vld     = vld_at[c];
            ovr_clr = clr_at[c];
            #1;
            wrt_l[c] = wrt_smpl;  clr_l[c] = mac_clr;  en_l[c] = mac_en;
            bd_l[c] = band_done;  sd_l[c] = seq_done;  busy_l[c] = busy;
            ovr_l[c] = ovr;       band_l[c] = int'(band);  tap_l[c] = int'(tap_addr);
            s_wrt_l[c] = s_wrt;   s_en_l[c] = s_en;    s_bd_l[c] = s_bd;
            s_sd_l[c] = s_sd;     s_busy_l[c] = s_busy; s_tap_l[c] = int'(s_tap);
        end
        vld = 1'b0;
        ovr_clr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic check_full_seq(input string t);
        check({t, "_wrt_c1"}, int'(wrt_l[1]), 1);
        check({t, "_wrt_cnt"}, ones(wrt_l, 0, 178), 1);
        for (int b = 0; b < 5; b++) begin
            check({t, "_bd_cycle"}, int'(bd_l[36 + 35 * b]), 1);
            check({t, "_bd_band"}, band_l[36 + 35 * b], b);
        end
        check({t, "_bd_cnt"}, ones(bd_l, 0, 178), 5);
        check({t, "_sd_176"}, int'(sd_l[176]), 1);
        check({t, "_sd_cnt"}, ones(sd_l, 0, 178), 1);
        check({t, "_busy_176"}, int'(busy_l[176]), 1);
        check({t, "_busy_177"}, int'(busy_l[177]), 0);
        check({t, "_busy_cnt"}, ones(busy_l, 0, 178), 176);
        check({t, "_clr_cnt"}, ones(clr_l, 0, 178), 5);
        check({t, "_en_cnt"}, ones(en_l, 0, 178), 155);
    endtask

    initial begin
        clear_stim();
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_band", int'(band), 0);
        check("rst_tap", int'(tap_addr), 0);
        check("rst_ovr", int'(ovr), 0);
        check("rst_pulses", int'({wrt_smpl, mac_clr, mac_en, band_done, seq_done}), 0);
        repeat (2) @(posedge clk);

        // Full default sequence
        clear_stim();
        vld_at[0] = 1'b1;
        run(180);
        check_full_seq("seq");
        check("seq_tap_clr", tap_l[2], 0);
        check("seq_clr_c2", int'(clr_l[2]), 1);
        check("seq_tap_first", tap_l[3], 0);
        check("seq_tap_last", tap_l[33], 30);
        check("seq_en_c34", int'(en_l[34]), 0);
        check("seq_tap_hold", tap_l[35], 30);
        check("seq_ovr", ones(ovr_l, 0, 180), 0);

        // Queues not primed
        clear_stim();
        q_full = 1'b0;
        vld_at[0] = 1'b1;
        run(10);
        check("nq_wrt_c1", int'(wrt_l[1]), 1);
        check("nq_wrt_cnt", ones(wrt_l, 0, 10), 1);
        check("nq_busy_cnt", ones(busy_l, 0, 10), 1);
        check("nq_mac", ones(clr_l, 0, 10) + ones(en_l, 0, 10), 0);
        check("nq_done", ones(bd_l, 0, 10) + ones(sd_l, 0, 10), 0);
        q_full = 1'b1;

        // Overrun while busy
        clear_stim();
        vld_at[0] = 1'b1; vld_at[50] = 1'b1; vld_at[100] = 1'b1; vld_at[176] = 1'b1;
        clr_at[60] = 1'b1; clr_at[100] = 1'b1; clr_at[150] = 1'b1;
        run(180);
        check_full_seq("ovr");
        check("ovr_c50", int'(ovr_l[50]), 0);
        check("ovr_c51", int'(ovr_l[51]), 1);
        check("ovr_clr_c61", int'(ovr_l[61]), 0);
        check("ovr_setwins_c101", int'(ovr_l[101]), 1);
        check("ovr_clr_c151", int'(ovr_l[151]), 0);
        check("ovr_bdone_c177", int'(ovr_l[177]), 1);
        check("ovr_no_restart", int'(wrt_l[177]), 0);
        clear_stim();
        clr_at[0] = 1'b1;
        run(2);

        // Reset mid-sequence
        clear_stim();
        vld_at[0] = 1'b1; vld_at[50] = 1'b1;
        for (int i = 80; i < 83; i++) rst_at[i] = 1'b1;
        run(260);
        check("mr_pre_band", band_l[79], 2);
        check("mr_pre_ovr", int'(ovr_l[79]), 1);
        check("mr_busy", int'(busy_l[80]), 0);
        check("mr_band", band_l[80], 0);
        check("mr_tap", tap_l[80], 0);
        check("mr_ovr", int'(ovr_l[80]), 0);
        check("mr_macen", int'(en_l[80]), 0);
        check("mr_bd_after", ones(bd_l, 80, 260), 0);
        check("mr_sd_after", ones(sd_l, 80, 260), 0);
        check("mr_busy_after", ones(busy_l, 80, 260), 0);
        clear_stim();
        vld_at[0] = 1'b1;
        run(180);
        check_full_seq("mr_next");

        // Short instance: NUM_TAPS=4, MAC_LAT=0
        clear_stim();
        vld_at[0] = 1'b1;
        run(40);
        check("sh_wrt_c1", int'(s_wrt_l[1]), 1);
        for (int b = 0; b < 5; b++) check("sh_bd_cycle", int'(s_bd_l[7 + 6 * b]), 1);
        check("sh_bd_cnt", ones(s_bd_l, 0, 40), 5);
        check("sh_sd_31", int'(s_sd_l[31]), 1);
        check("sh_sd_cnt", ones(s_sd_l, 0, 40), 1);
        check("sh_busy_cnt", ones(s_busy_l, 0, 40), 31);
        check("sh_busy_32", int'(s_busy_l[32]), 0);
        check("sh_en_cnt", ones(s_en_l, 0, 40), 20);
        check("sh_en_band0", ones(s_en_l, 0, 8), 4);
        for (int t = 0; t < 4; t++) check("sh_tap", s_tap_l[3 + t], t);
        check("sh_en_c7", int'(s_en_l[7]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eq_sequencer.md
EQ_SEQUENCER -- requirements
Module: eq_sequencer

Interface
REQ-001 Parameter NUM_TAPS, default 31: taps per band FIR; legal range 2..2^TAP_W.
REQ-002 Parameter TAP_W, default 5: width of tap_addr.
REQ-003 Parameter MAC_LAT, default 2: pipeline depth of the shared multiply-accumulate datapath, in cycles; legal range 0..7.
REQ-004 clk  input  1  system clock, 50MHz.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 vld  input  1  one-cycle pulse: new left/right sample pair available from I2S slave.
REQ-007 q_full  input  1  sample queues primed; filtering permitted.
REQ-008 band_en  input  5  per-band enable [0]=LP,[1]=B1,[2]=B2,[3]=B3,[4]=HP (used only under EQ_SEQ_SKIP_EN).
REQ-009 ovr_clr  input  1  clears ovr.
REQ-010 wrt_smpl  output  1  one-cycle pulse: write new samples into all band queues.
REQ-011 band  output  3  current band index 0..4.
REQ-012 tap_addr  output  TAP_W  coefficient/queue read index for current band.
REQ-013 mac_clr  output  1  clear both channel accumulators.
REQ-014 mac_en  output  1  accumulate current tap, both channels in parallel.
REQ-015 band_done  output  1  one-cycle pulse: accumulator result for band is valid, latch it.
REQ-016 seq_done  output  1  one-cycle pulse: all bands complete, downstream updates aud_out.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 ovr  output  1  sticky overrun flag.

Function
REQ-019 FSM states SHALL be IDLE, WRT, CLR, MAC, PIPE, BDONE.
REQ-020 IDLE: vld=1 -> WRT next cycle; otherwise stay.
REQ-021 WRT: wrt_smpl=1 for exactly one cycle; q_full=1 -> CLR with band=0; q_full=0 -> IDLE, no seq_done.
REQ-022 CLR: mac_clr=1, tap_addr=0, one cycle -> MAC.
REQ-023 MAC: mac_en=1 for exactly NUM_TAPS cycles, tap_addr=0..NUM_TAPS-1 incrementing each cycle, no wrap.
REQ-024 PIPE: mac_en=0 for MAC_LAT cycles (skipped when MAC_LAT=0) -> BDONE.
REQ-025 BDONE: band_done=1 one cycle; band<4 -> band+1, CLR; band=4 -> seq_done=1 same cycle, band=0, IDLE.
REQ-026 Total cycles from WRT through final BDONE inclusive = 1+5*(NUM_TAPS+MAC_LAT+2); defaults 176.
REQ-027 band, tap_addr SHALL hold value outside states that drive them; mac_clr, mac_en, wrt_smpl, band_done, seq_done SHALL be 0 except as stated.
REQ-028 vld while busy=1: vld ignored, ovr set next cycle; sequence continues unaffected.
REQ-029 ovr cleared by ovr_clr=1; simultaneous set and clear: set wins.
REQ-030 vld in the cycle BDONE returns to IDLE counts as busy (overrun).

Reset
REQ-031 rst_n low SHALL immediately force IDLE, band=0, tap_addr=0, ovr=0, all pulse outputs and busy 0.
REQ-032 Reset mid-sequence SHALL abandon the sequence; no band_done or seq_done issued after release until a new vld.

Configuration
REQ-033 Macro EQ_SEQ_SKIP_EN defined: bands with band_en[n]=0 skip CLR/MAC/PIPE/BDONE entirely (no band_done); seq_done then accompanies the last enabled band's BDONE; all bands disabled -> WRT goes to IDLE with seq_done=1 on the WRT cycle.
REQ-034 Macro undefined: band_en ignored, all five bands always processed per REQ-025.

Verification
REQ-035 Defaults, q_full=1, vld pulse at cycle 0 -> wrt_smpl at cycle 1, band_done at cycles 36,71,106,141,176, seq_done at 176 only, busy low at 177.
REQ-036 q_full=0, vld pulse -> single wrt_smpl, busy high one cycle, no mac_clr/mac_en/band_done/seq_done.
REQ-037 Second vld at cycle 50 of sequence -> ovr=1 at cycle 51, timing identical to REQ-035; ovr_clr and vld-while-busy same cycle -> ovr stays 1.
REQ-038 rst_n low at cycle 80 for 3 cycles -> all outputs 0 immediately, no band_done after release; next vld produces full 176-cycle sequence.
REQ-039 EQ_SEQ_SKIP_EN defined, band_en=5'b10101 -> band_done at cycles 36,71,106 with band=0,2,4, seq_done at 106; band_en=0 -> seq_done at cycle 1.
REQ-040 MAC_LAT=0, NUM_TAPS=4 -> sequence length 31 cycles, tap_addr 0,1,2,3 per band with mac_en exactly 4 cycles.
